// File: rtl/ledr_ctrl.sv
// LED controller slave on the picorv32 native bus: direct, blink, chaser and PWM modes.
module ledr_ctrl #(
    parameter logic [31:0]      BASE_ADDR    = 32'h0300_0000,
    parameter int unsigned      NUM_LEDS     = 10,
    parameter int unsigned      DIV_W        = 24,
    parameter logic [DIV_W-1:0] RESET_PERIOD = DIV_W'(12_499_999)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic [NUM_LEDS-1:0] ledr
);

    localparam logic [5:0] W_CTRL   = 6'd0;
    localparam logic [5:0] W_DATA   = 6'd1;
    localparam logic [5:0] W_PERIOD = 6'd2;
    localparam logic [5:0] W_DUTY   = 6'd3;
    localparam logic [5:0] W_STATUS = 6'd4;

    localparam logic [1:0] M_DIRECT = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_CHASER = 2'd2;
    localparam logic [1:0] M_PWM    = 2'd3;

    localparam int unsigned STATUS_LED_LSB = 16;

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t state, state_n;

    // architectural registers and their next values
    logic                en, en_n;
    logic [1:0]          mode, mode_n;
    logic [NUM_LEDS-1:0] data, data_n;
    logic [DIV_W-1:0]    period, period_n;
    logic [7:0]          duty, duty_n;
    logic [DIV_W-1:0]    cnt, cnt_n;
    logic                phase, phase_n;
    logic [NUM_LEDS-1:0] shreg, shreg_n;
    logic [7:0]          pwm_cnt, pwm_n;
    logic [NUM_LEDS-1:0] ledr_n;

    logic        hit, we, tick;
    logic        wr_ctrl, wr_data, wr_period, wr_duty;
    logic [5:0]  word;
    logic [31:0] rd_val, wr_val;
    logic        unused_bits;

    assign word        = mem_addr[7:2];
    assign hit         = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign we          = (state == ACK) && (mem_wstrb != 4'd0);
    assign wr_ctrl     = we && (word == W_CTRL);
    assign wr_data     = we && (word == W_DATA);
    assign wr_period   = we && (word == W_PERIOD);
    assign wr_duty     = we && (word == W_DUTY);
    assign tick        = en && (cnt == period);
    assign unused_bits = ^{mem_addr[1:0], wr_val};

    // read mux over the register map; unmapped words read as zero
    always_comb begin
        rd_val = 32'd0;
        case (word)
            W_CTRL:   rd_val = {29'd0, mode, en};
            W_DATA:   rd_val = 32'(data);
            W_PERIOD: rd_val = 32'(period);
            W_DUTY:   rd_val = 32'(duty);
            W_STATUS: rd_val = (32'(ledr) << STATUS_LED_LSB) | 32'(phase);
            default:  rd_val = 32'd0;
        endcase
    end

    // byte-strobe merge of write data onto the addressed register
    always_comb begin
        wr_val = rd_val;
        for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) begin
                wr_val[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    // bus FSM next state: one ACK cycle per decoded request
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (hit) state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // bus FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // registered acknowledge and read data, zero outside the ACK cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            mem_ready <= (state_n == ACK);
            mem_rdata <= (state_n == ACK) ? rd_val : 32'd0;
        end
    end

    // datapath next values: timebase first, bus writes override, LED drive from the result
    always_comb begin
        en_n     = en;
        mode_n   = mode;
        data_n   = data;
        period_n = period;
        duty_n   = duty;
        cnt_n    = en ? (tick ? '0 : cnt + DIV_W'(1)) : '0;
        phase_n  = (tick && mode == M_BLINK) ? ~phase : phase;
        pwm_n    = en ? pwm_cnt + 8'd1 : pwm_cnt;
        shreg_n  = (tick && mode == M_CHASER) ? {shreg[NUM_LEDS-2:0], shreg[NUM_LEDS-1]} : shreg;
        ledr_n   = '0;

        if (wr_ctrl) begin
            en_n   = wr_val[0];
            mode_n = wr_val[2:1];
            if (mode_n != mode) begin
                cnt_n   = '0;
                phase_n = 1'b0;
            end
            if (mode_n == M_CHASER) shreg_n = data;
        end
        if (wr_data) begin
            data_n = wr_val[NUM_LEDS-1:0];
            if (mode == M_CHASER) shreg_n = data_n;
        end
        if (wr_period) begin
            period_n = wr_val[DIV_W-1:0];
            cnt_n    = '0;
        end
        if (wr_duty) duty_n = wr_val[7:0];

        if (!en_n) begin
            cnt_n   = '0;
            phase_n = 1'b0;
        end else begin
            case (mode_n)
                M_DIRECT: ledr_n = data_n;
                M_BLINK:  ledr_n = phase_n ? data_n : '0;
                M_CHASER: ledr_n = shreg_n;
                M_PWM:    ledr_n = (pwm_n < duty_n) ? data_n : '0;
                default:  ledr_n = '0;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en      <= 1'b0;
            mode    <= M_DIRECT;
            data    <= '0;
            period  <= RESET_PERIOD;
            duty    <= 8'h80;
            cnt     <= '0;
            phase   <= 1'b0;
            shreg   <= '0;
            pwm_cnt <= 8'd0;
            ledr    <= '0;
        end else begin
            en      <= en_n;
            mode    <= mode_n;
            data    <= data_n;
            period  <= period_n;
            duty    <= duty_n;
            cnt     <= cnt_n;
            phase   <= phase_n;
            shreg   <= shreg_n;
            pwm_cnt <= pwm_n;
            ledr    <= ledr_n;
        end
    end

endmodule
